// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: next-pc selects, ALU function codes
// and the RV32 base opcodes this stage understands.
package decode_pkg;

  typedef enum logic [2:0] {
    PC_FROM_PC_PLUS_4 = 3'd0,
    PC_PLUS_JAL_IMM   = 3'd1,
    NEXT_PC_FROM_RF   = 3'd2,
    PC_PLUS_BRCH_IMM  = 3'd3
  } next_pc_sel_t;

  typedef enum logic [3:0] {
    AplusB    = 4'd0,
    AminusB   = 4'd1,
    AminusB_U = 4'd2,
    AandB     = 4'd3,
    AorB      = 4'd4,
    AxorB     = 4'd5,
    AltB      = 4'd6
  } function_code_t;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Signed branch compares (BEQ/BNE/BLT/BGE) share funct3[1]=0.
  function automatic logic is_signed_branch(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: instruction word -> control
// fields and sign-extended immediate. Unknown encodings decode to a safe,
// non-writing, sequential-pc bundle with illegal set.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FULL_BRANCH = 1
) (
  input  logic [31:0]     inst,
  output logic [2:0]      next_pc_sel,
  output logic [3:0]      function_code,
  output logic            we,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic            we_raw;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  // All immediates sign-extend from inst[31].
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Opcode/funct decode; any unmatched path falls through to illegal.
  always_comb begin
    next_pc_sel   = PC_FROM_PC_PLUS_4;
    function_code = AplusB;
    we_raw        = 1'b0;
    imm           = '0;
    illegal       = 1'b0;
    case (opcode)
      OPC_JAL: begin
        next_pc_sel = PC_PLUS_JAL_IMM;
        we_raw      = 1'b1;
        imm         = imm_j;
      end
      OPC_JALR: begin
        next_pc_sel = NEXT_PC_FROM_RF;
        we_raw      = 1'b1;
        imm         = imm_i;
        illegal     = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        next_pc_sel = PC_PLUS_BRCH_IMM;
        imm         = imm_b;
        if (f3 == 3'b000) begin
          function_code = AminusB;
        end else if (FULL_BRANCH != 0 && is_signed_branch(f3)) begin
          function_code = AminusB;
        end else if (FULL_BRANCH != 0 && (f3 == 3'b110 || f3 == 3'b111)) begin
          function_code = AminusB_U;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        we_raw = 1'b1;
        imm    = imm_i;
        case (f3)
          3'b000:  function_code = AplusB;
          3'b111:  function_code = AandB;
          3'b110:  function_code = AorB;
          3'b100:  function_code = AxorB;
          3'b010:  function_code = AltB;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        we_raw = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            3'b000:  function_code = AplusB;
            3'b111:  function_code = AandB;
            3'b110:  function_code = AorB;
            3'b100:  function_code = AxorB;
            default: illegal = 1'b1;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          function_code = AminusB;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
    // Illegal encodings must not redirect the pc or write the register file.
    if (illegal) begin
      next_pc_sel   = PC_FROM_PC_PLUS_4;
      function_code = AplusB;
      we_raw        = 1'b0;
      imm           = '0;
    end
  end

  // x0 is hardwired to zero, so a write to it is suppressed here.
  assign we = we_raw & (rd != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one output register around decode_comb.
//
// Handshake: a transfer happens on a port in any cycle where valid & ready
// are both high; valid, once raised, stays high with stable data until that
// transfer. in_ready depends only on the output register state and out_ready,
// never on in_valid. flush drops the held bundle and blocks any same-cycle
// accept.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int FULL_BRANCH = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_next_pc_sel,
  output logic [3:0]      out_function_code,
  output logic            out_we,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  logic [2:0]      d_next_pc_sel;
  logic [3:0]      d_function_code;
  logic            d_we;
  logic [4:0]      d_rd;
  logic [4:0]      d_rs1;
  logic [4:0]      d_rs2;
  logic [XLEN-1:0] d_imm;
  logic            d_illegal;
  logic            accept;

  decode_comb #(
    .XLEN        (XLEN),
    .FULL_BRANCH (FULL_BRANCH)
  ) u_decode_comb (
    .inst          (in_inst),
    .next_pc_sel   (d_next_pc_sel),
    .function_code (d_function_code),
    .we            (d_we),
    .rd            (d_rd),
    .rs1           (d_rs1),
    .rs2           (d_rs2),
    .imm           (d_imm),
    .illegal       (d_illegal)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Output register: reset, then flush, then load (covers drain+refill), then drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_next_pc_sel   <= PC_FROM_PC_PLUS_4;
      out_function_code <= AplusB;
      out_we            <= 1'b0;
      out_rd            <= '0;
      out_rs1           <= '0;
      out_rs2           <= '0;
      out_imm           <= '0;
      out_pc            <= '0;
      out_illegal       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_next_pc_sel   <= d_next_pc_sel;
      out_function_code <= d_function_code;
      out_we            <= d_we;
      out_rd            <= d_rd;
      out_rs1           <= d_rs1;
      out_rs2           <= d_rs2;
      out_imm           <= d_imm;
      out_pc            <= in_pc;
      out_illegal       <= d_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
